// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit byte sequencer.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_WAIT_DONE,
    ST_EOP,
    ST_GAP
  } tx_seq_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam int DEF_CLKS_PER_BIT = 4;
  localparam int DEF_EOP_BITS     = 2;
  localparam int DEF_IDLE_BITS    = 1;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-rate tick generator: counts 0..CLKS_PER_BIT-1 while enabled and
// flags the wrap cycle. Shared with the receive side.
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With CLKS_PER_BIT = 1 the count is pinned at 0, so every enabled cycle ticks.
  assign tick = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/usb_tx_byte_sequencer.sv
// Transmit byte sequencer: drives the PISO with SYNC then payload bytes,
// paces bit strobes, and closes the packet with EOP and an idle gap.
module usb_tx_byte_sequencer
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int EOP_BITS     = DEF_EOP_BITS,
  parameter int IDLE_BITS    = DEF_IDLE_BITS
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       piso_load,
  output logic [7:0] piso_data,
  output logic       piso_shift_enable,
  input  logic       piso_busy,
  input  logic       piso_done,
  output logic       eop,
  output logic       tx_active,
  output logic       tx_done,
  output logic       underrun
);

  localparam logic [15:0] EOP_LAST = 16'(EOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [15:0] GAP_LAST = 16'(IDLE_BITS * CLKS_PER_BIT - 1);

  tx_seq_state_t state_q, state_d;
  logic [7:0]    byte_q, byte_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          last_flag_q, last_flag_d;
  logic [2:0]    shift_cnt_q, shift_cnt_d;
  logic [15:0]   cyc_cnt_q, cyc_cnt_d;
  logic          tx_active_q, tx_active_d;
  logic          tx_done_q, tx_done_d;
  logic          underrun_q, underrun_d;
  logic          tick;
  logic          accept;
  logic          shift_strobe;

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk    (clk),
    .nRST   (nRST),
    .clear  (state_q == ST_LOAD),
    .enable (state_q == ST_SHIFT),
    .tick   (tick)
  );

  assign tx_ready = tx_active_q && !hold_full_q && !last_flag_q &&
                    (state_q != ST_EOP) && (state_q != ST_GAP);
  assign accept   = tx_valid && tx_ready;

  // Load strobe waits for the PISO to be free; data is only presented with it.
  assign piso_load         = (state_q == ST_LOAD) && !piso_busy;
  assign piso_data         = piso_load ? byte_q : 8'h00;
  assign shift_strobe      = (state_q == ST_SHIFT) && tick && piso_busy;
  assign piso_shift_enable = shift_strobe;
  assign eop               = (state_q == ST_EOP);
  assign tx_active         = tx_active_q;
  assign tx_done           = tx_done_q;
  assign underrun          = underrun_q;

  // Next-state logic for the packet sequencer and its one-byte hold register.
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_flag_d = last_flag_q;
    shift_cnt_d = shift_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    tx_active_d = tx_active_q;
    tx_done_d   = 1'b0;
    underrun_d  = 1'b0;

    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
      if (tx_last) begin
        last_flag_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        last_flag_d = 1'b0;
        hold_full_d = 1'b0;
        if (tx_start) begin
          byte_d      = SYNC_BYTE;
          tx_active_d = 1'b1;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!piso_busy) begin
          shift_cnt_d = 3'd0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shift_strobe) begin
          shift_cnt_d = shift_cnt_q + 3'd1;
          if (shift_cnt_q == 3'd7) begin
            state_d = ST_WAIT_DONE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (piso_done) begin
          if (hold_full_q) begin
            byte_d      = hold_q;
            hold_full_d = 1'b0;
            state_d     = ST_LOAD;
          end else if (accept) begin
            // Byte arriving in the same cycle as done goes straight to the PISO.
            byte_d      = tx_data;
            hold_full_d = 1'b0;
            state_d     = ST_LOAD;
          end else begin
            underrun_d = !last_flag_q;
            cyc_cnt_d  = 16'd0;
            state_d    = ST_EOP;
          end
        end
      end
      ST_EOP: begin
        if (cyc_cnt_q == EOP_LAST) begin
          cyc_cnt_d = 16'd0;
          state_d   = ST_GAP;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (cyc_cnt_q == GAP_LAST) begin
          cyc_cnt_d   = 16'd0;
          tx_done_d   = 1'b1;
          tx_active_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      byte_q      <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      last_flag_q <= 1'b0;
      shift_cnt_q <= 3'd0;
      cyc_cnt_q   <= 16'd0;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      last_flag_q <= last_flag_d;
      shift_cnt_q <= shift_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_usb_tx_byte_sequencer.sv
// Self-checking bench for usb_tx_byte_sequencer: two instances (4 and 1
// clocks per bit) driven through a common stimulus path, each with a
// behavioural PISO, checked against an event schedule computed from the
// packet timing rules.
module tb_usb_tx_byte_sequencer;
  import usb_tx_pkg::*;

  localparam int EOPB  = 2;
  localparam int IDLEB = 1;

  logic       clk = 1'b0;
  logic       nRST = 1'b0;
  logic       sel = 1'b0;
  logic       tx_start = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic [7:0] tx_data = 8'h00;

  always #5 clk = ~clk;

  logic       start4, valid4, ready4, load4, shift4, eop4, active4, done4, und4, busy4, pdone4;
  logic       start1, valid1, ready1, load1, shift1, eop1, active1, done1, und1, busy1, pdone1;
  logic [7:0] data4, data1;

  assign start4 = tx_start && !sel;
  assign valid4 = tx_valid && !sel;
  assign start1 = tx_start && sel;
  assign valid1 = tx_valid && sel;

  usb_tx_byte_sequencer #(.CLKS_PER_BIT(4), .EOP_BITS(EOPB), .IDLE_BITS(IDLEB)) dut4 (
    .clk(clk), .nRST(nRST), .tx_start(start4), .tx_data(tx_data), .tx_valid(valid4),
    .tx_last(tx_last), .tx_ready(ready4), .piso_load(load4), .piso_data(data4),
    .piso_shift_enable(shift4), .piso_busy(busy4), .piso_done(pdone4), .eop(eop4),
    .tx_active(active4), .tx_done(done4), .underrun(und4)
  );

  usb_tx_byte_sequencer #(.CLKS_PER_BIT(1), .EOP_BITS(EOPB), .IDLE_BITS(IDLEB)) dut1 (
    .clk(clk), .nRST(nRST), .tx_start(start1), .tx_data(tx_data), .tx_valid(valid1),
    .tx_last(tx_last), .tx_ready(ready1), .piso_load(load1), .piso_data(data1),
    .piso_shift_enable(shift1), .piso_busy(busy1), .piso_done(pdone1), .eop(eop1),
    .tx_active(active1), .tx_done(done1), .underrun(und1)
  );

  // Behavioural PISOs: busy from load until the 8th shift, done one cycle after it.
  int pcnt4 = 0;
  int pcnt1 = 0;
  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      busy4 <= 1'b0; pdone4 <= 1'b0; pcnt4 <= 0;
    end else begin
      pdone4 <= 1'b0;
      if (load4) begin
        busy4 <= 1'b1; pcnt4 <= 0;
      end else if (shift4 && busy4) begin
        pcnt4 <= pcnt4 + 1;
        if (pcnt4 == 7) begin busy4 <= 1'b0; pdone4 <= 1'b1; end
      end
    end
  end
  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      busy1 <= 1'b0; pdone1 <= 1'b0; pcnt1 <= 0;
    end else begin
      pdone1 <= 1'b0;
      if (load1) begin
        busy1 <= 1'b1; pcnt1 <= 0;
      end else if (shift1 && busy1) begin
        pcnt1 <= pcnt1 + 1;
        if (pcnt1 == 7) begin busy1 <= 1'b0; pdone1 <= 1'b1; end
      end
    end
  end

  // Selected-instance view.
  wire       o_ready  = sel ? ready1  : ready4;
  wire       o_load   = sel ? load1   : load4;
  wire [7:0] o_data   = sel ? data1   : data4;
  wire       o_shift  = sel ? shift1  : shift4;
  wire       o_eop    = sel ? eop1    : eop4;
  wire       o_active = sel ? active1 : active4;
  wire       o_done   = sel ? done1   : done4;
  wire       o_under  = sel ? und1    : und4;
  wire [14:0] outs4 = {ready4, load4, data4, shift4, eop4, active4, done4, und4};
  wire [14:0] outs1 = {ready1, load1, data1, shift1, eop1, active1, done1, und1};

  // Event monitor: cycle index of every observed event, sampled on negedge.
  int cyc = 0;
  int load_t[$], load_d[$], strobe_t[$], eop_t[$], done_t[$], und_t[$], hs_t[$], hs_d[$], act_t[$];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (o_load) begin load_t.push_back(cyc); load_d.push_back(int'(o_data)); end
    if (o_shift) strobe_t.push_back(cyc);
    if (o_eop) eop_t.push_back(cyc);
    if (o_done) done_t.push_back(cyc);
    if (o_under) und_t.push_back(cyc);
    if (o_active) act_t.push_back(cyc);
    if (tx_valid && o_ready) begin hs_t.push_back(cyc); hs_d.push_back(int'(tx_data)); end
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] pay[$];

  // Reference schedule.
  int exp_load_t[$], exp_load_d[$], exp_strobe_t[$], exp_eop_t[$];
  int exp_done, exp_und;

  task automatic clear_mon();
    load_t.delete(); load_d.delete(); strobe_t.delete(); eop_t.delete();
    done_t.delete(); und_t.delete(); hs_t.delete(); hs_d.delete(); act_t.delete();
  endtask

  // Timing from the packet rules: loads one byte period (8c+2) apart, strobes
  // every c cycles after each load, EOP starts one period after the last load,
  // then EOP_BITS*c eop cycles and IDLE_BITS*c gap cycles before tx_done.
  task automatic build_expect(input int l0, input int c, input int nb, input bit abort);
    int e;
    exp_load_t.delete(); exp_load_d.delete(); exp_strobe_t.delete(); exp_eop_t.delete();
    for (int k = 0; k <= nb; k++) begin
      exp_load_t.push_back(l0 + k * (8 * c + 2));
      exp_load_d.push_back((k == 0) ? 32'h80 : int'(pay[k-1]));
      for (int j = 1; j <= 8; j++) exp_strobe_t.push_back(l0 + k * (8 * c + 2) + c * j);
    end
    e = l0 + nb * (8 * c + 2) + 8 * c + 2;
    for (int i = 0; i < EOPB * c; i++) exp_eop_t.push_back(e + i);
    exp_done = e + EOPB * c + IDLEB * c;
    exp_und  = abort ? e : -1;
  endtask

  function automatic int diff_idx(input int a[$], input int b[$]);
    if (a.size() != b.size()) return -2;
    foreach (a[i]) if (a[i] != b[i]) return i;
    return -1;
  endfunction

  // Start a packet, feed pay[0..nb-1] over valid/ready, run until tx_done.
  task automatic run_packet(input int nb, input bit with_last, input int stray,
                            output int l0, output bit timeout);
    int idx = 0;
    bit hs, gotdone;
    @(posedge clk); #1;
    l0 = cyc + 1;
    tx_start = 1'b1;
    tx_valid = (nb > 0);
    tx_data  = (nb > 0) ? pay[0] : 8'h00;
    tx_last  = with_last && (nb == 1);
    timeout  = 1'b1;
    for (int guard = 0; guard < 2000; guard++) begin
      @(negedge clk);
      hs = tx_valid && o_ready;
      gotdone = o_done;
      @(posedge clk); #1;
      tx_start = (stray > 0) && (cyc == l0 + stray);
      if (hs) begin
        idx++;
        if (idx < nb) begin
          tx_data = pay[idx];
          tx_last = with_last && (idx == nb - 1);
        end else begin
          tx_valid = 1'b0; tx_last = 1'b0;
        end
      end
      if (gotdone) begin timeout = 1'b0; break; end
    end
    tx_start = 1'b0; tx_valid = 1'b0; tx_last = 1'b0;
    $display("packet cpb=%0d bytes=%0d last=%0d start_cycle=%0d loads=%0d", sel ? 1 : 4, nb, with_last, l0, load_t.size());
  endtask

  task automatic test_reset();
    bit bad = 1'b0;
    nRST = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({outs4, outs1} !== 30'd0) begin
      errors++; $display("FAIL reset_outputs got %h required 0", {outs4, outs1});
    end
    nRST = 1'b1;
    repeat (6) begin @(negedge clk); if ({outs4, outs1} !== 30'd0) bad = 1'b1; end
    checks++;
    if (bad) begin errors++; $display("FAIL reset_release_quiet got activity required none"); end
  endtask

  task automatic test_single_byte();
    int l0, d; bit to;
    sel = 1'b0; pay.delete(); pay.push_back(8'hA5); clear_mon();
    run_packet(1, 1'b1, 0, l0, to);
    repeat (8) @(negedge clk);
    build_expect(l0, 4, 1, 1'b0);
    checks++; if (to) begin errors++; $display("FAIL single_timeout got no tx_done required tx_done"); end
    d = diff_idx(load_t, exp_load_t); checks++;
    if (d != -1) begin errors++; $display("FAIL single_load_times got n=%0d diff=%0d required n=%0d first=%0d", load_t.size(), d, exp_load_t.size(), l0); end
    d = diff_idx(load_d, exp_load_d); checks++;
    if (d != -1) begin errors++; $display("FAIL single_load_data diff=%0d required 80,a5", d); end
    d = diff_idx(strobe_t, exp_strobe_t); checks++;
    if (d != -1) begin errors++; $display("FAIL single_strobes got n=%0d diff=%0d required n=16", strobe_t.size(), d); end
    d = diff_idx(eop_t, exp_eop_t); checks++;
    if (d != -1) begin errors++; $display("FAIL single_eop got n=%0d diff=%0d required n=8", eop_t.size(), d); end
    checks++;
    if (done_t.size() != 1 || done_t[0] != exp_done) begin errors++; $display("FAIL single_done got n=%0d required one at %0d", done_t.size(), exp_done); end
    checks++;
    if (und_t.size() != 0) begin errors++; $display("FAIL single_underrun got %0d pulses required 0", und_t.size()); end
    checks++;
    if (act_t.size() != exp_done - l0) begin errors++; $display("FAIL single_active got %0d cycles required %0d", act_t.size(), exp_done - l0); end
  endtask

  task automatic test_back_to_back();
    int l0, d; bit to, bad;
    sel = 1'b0; pay = '{8'h11, 8'h22, 8'h33}; clear_mon();
    run_packet(3, 1'b1, 0, l0, to);
    repeat (8) @(negedge clk);
    build_expect(l0, 4, 3, 1'b0);
    d = diff_idx(load_t, exp_load_t); checks++;
    if (d != -1) begin errors++; $display("FAIL b2b_load_times got n=%0d diff=%0d required n=4", load_t.size(), d); end
    d = diff_idx(load_d, exp_load_d); checks++;
    if (d != -1) begin errors++; $display("FAIL b2b_load_data diff=%0d required 80,11,22,33", d); end
    bad = (hs_t.size() != 3);
    for (int k = 1; k < hs_t.size(); k++) if (hs_t[k] - hs_t[k-1] != 34) bad = 1'b1;
    for (int k = 0; k < hs_d.size() && k < 3; k++) if (hs_d[k] != int'(pay[k])) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL b2b_handshakes got n=%0d required 3 spaced 34 in order", hs_t.size()); end
    checks++;
    if (und_t.size() != 0) begin errors++; $display("FAIL b2b_underrun got %0d pulses required 0", und_t.size()); end
    checks++;
    if (to || done_t.size() != 1 || done_t[0] != exp_done) begin errors++; $display("FAIL b2b_done got n=%0d required one at %0d", done_t.size(), exp_done); end
  endtask

  task automatic test_underrun();
    int l0, d; bit to;
    sel = 1'b0; pay = '{8'h5A}; clear_mon();
    run_packet(1, 1'b0, 0, l0, to);
    repeat (8) @(negedge clk);
    build_expect(l0, 4, 1, 1'b1);
    d = diff_idx(load_d, exp_load_d); checks++;
    if (d != -1) begin errors++; $display("FAIL under_load_data diff=%0d required 80,5a", d); end
    checks++;
    if (und_t.size() != 1 || und_t[0] != exp_und) begin errors++; $display("FAIL under_pulse got n=%0d required one at %0d", und_t.size(), exp_und); end
    d = diff_idx(eop_t, exp_eop_t); checks++;
    if (d != -1) begin errors++; $display("FAIL under_eop got n=%0d diff=%0d required n=8", eop_t.size(), d); end
    checks++;
    if (to || done_t.size() != 1 || done_t[0] != exp_done) begin errors++; $display("FAIL under_done got n=%0d required one at %0d", done_t.size(), exp_done); end
  endtask

  task automatic test_start_ignored();
    int l0, d; bit to;
    sel = 1'b0; pay = '{8'h3C}; clear_mon();
    run_packet(1, 1'b1, 5, l0, to);
    repeat (40) @(negedge clk);
    build_expect(l0, 4, 1, 1'b0);
    d = diff_idx(load_t, exp_load_t); checks++;
    if (d != -1) begin errors++; $display("FAIL ignore_loads got n=%0d diff=%0d required n=2", load_t.size(), d); end
    checks++;
    if (to || done_t.size() != 1 || done_t[0] != exp_done) begin errors++; $display("FAIL ignore_done got n=%0d required one at %0d", done_t.size(), exp_done); end
  endtask

  task automatic test_reset_midpacket();
    int l0, d, idx; bit to, hs, bad;
    sel = 1'b0; clear_mon();
    @(posedge clk); #1;
    l0 = cyc + 1; idx = 0;
    tx_start = 1'b1; tx_data = 8'h11; tx_valid = 1'b1; tx_last = 1'b0;
    for (int guard = 0; guard < 200 && cyc < l0 + 50; guard++) begin
      @(negedge clk); hs = tx_valid && o_ready;
      @(posedge clk); #1; tx_start = 1'b0;
      if (hs) begin idx++; if (idx == 1) tx_data = 8'h22; else tx_valid = 1'b0; end
    end
    checks++;
    if (load_t.size() != 2 || load_d[1] != 32'h11) begin errors++; $display("FAIL rst_mid_setup got %0d loads required 2 ending 11", load_t.size()); end
    @(negedge clk); #2;
    nRST = 1'b0; tx_valid = 1'b0;
    #1;
    checks++;
    if (outs4 !== 15'd0) begin errors++; $display("FAIL rst_mid_outputs got %h required 0", outs4); end
    repeat (3) @(posedge clk); #1;
    nRST = 1'b1;
    bad = 1'b0;
    repeat (6) begin @(negedge clk); if (outs4 !== 15'd0) bad = 1'b1; end
    checks++;
    if (bad) begin errors++; $display("FAIL rst_mid_residual got activity required none"); end
    pay = '{8'hC3}; clear_mon();
    run_packet(1, 1'b1, 0, l0, to);
    repeat (8) @(negedge clk);
    build_expect(l0, 4, 1, 1'b0);
    d = diff_idx(load_t, exp_load_t); checks++;
    if (d != -1 || load_d.size() == 0 || load_d[0] != 32'h80) begin errors++; $display("FAIL rst_mid_clean_packet got n=%0d diff=%0d required sync first at %0d", load_t.size(), d, l0); end
  endtask

  task automatic test_cpb1();
    int l0, d; bit to;
    sel = 1'b1; pay = '{8'hFF}; clear_mon();
    run_packet(1, 1'b1, 0, l0, to);
    repeat (8) @(negedge clk);
    build_expect(l0, 1, 1, 1'b0);
    d = diff_idx(load_t, exp_load_t); checks++;
    if (d != -1) begin errors++; $display("FAIL cpb1_loads got n=%0d diff=%0d required period 10", load_t.size(), d); end
    d = diff_idx(strobe_t, exp_strobe_t); checks++;
    if (d != -1) begin errors++; $display("FAIL cpb1_strobes got n=%0d diff=%0d required 8 consecutive per byte", strobe_t.size(), d); end
    d = diff_idx(eop_t, exp_eop_t); checks++;
    if (d != -1) begin errors++; $display("FAIL cpb1_eop got n=%0d diff=%0d required n=2", eop_t.size(), d); end
    checks++;
    if (to || done_t.size() != 1 || done_t[0] != exp_done) begin errors++; $display("FAIL cpb1_done got n=%0d required one at %0d", done_t.size(), exp_done); end
    sel = 1'b0;
  endtask

  task automatic test_random();
    int l0, d, nb, c; bit to, wl, abort, bad;
    for (int it = 0; it < 8; it++) begin
      sel = 1'($urandom_range(0, 1));
      c   = sel ? 1 : 4;
      nb  = $urandom_range(0, 3);
      wl  = 1'($urandom_range(0, 1));
      abort = !(wl && nb > 0);
      pay.delete();
      for (int k = 0; k < nb; k++) pay.push_back(8'($urandom_range(0, 255)));
      clear_mon();
      run_packet(nb, wl, 0, l0, to);
      repeat (6) @(negedge clk);
      build_expect(l0, c, nb, abort);
      bad = (diff_idx(load_t, exp_load_t) != -1) || (diff_idx(load_d, exp_load_d) != -1);
      checks++;
      if (bad) begin errors++; $display("FAIL rand%0d_loads got n=%0d required n=%0d", it, load_t.size(), exp_load_t.size()); end
      d = diff_idx(strobe_t, exp_strobe_t); checks++;
      if (d != -1) begin errors++; $display("FAIL rand%0d_strobes got n=%0d diff=%0d required n=%0d", it, strobe_t.size(), d, exp_strobe_t.size()); end
      d = diff_idx(eop_t, exp_eop_t); checks++;
      if (d != -1) begin errors++; $display("FAIL rand%0d_eop got n=%0d diff=%0d required n=%0d", it, eop_t.size(), d, exp_eop_t.size()); end
      checks++;
      if (to || done_t.size() != 1 || done_t[0] != exp_done) begin errors++; $display("FAIL rand%0d_done got n=%0d required one at %0d", it, done_t.size(), exp_done); end
      checks++;
      if (abort ? (und_t.size() != 1 || und_t[0] != exp_und) : (und_t.size() != 0)) begin
        errors++; $display("FAIL rand%0d_underrun got n=%0d required %0d", it, und_t.size(), abort ? 1 : 0);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_start_ignored();
    test_reset_midpacket();
    test_cpb1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_tx_byte_sequencer.md
Name: usb_tx_byte_sequencer

Overview:
Transmit-side controller that sequences the team's 8-bit PISO shift register for one USB packet.
- Loads the SYNC byte, then streams payload bytes taken from an upstream valid/ready byte interface.
- Generates the bit-rate shift strobe and signals EOP.
- Sits between the packet/protocol layer and the PISO datapath; no serial data passes through it.

Parameters:
CLKS_PER_BIT, 4, clk cycles per bit time (>=1)
EOP_BITS, 2, bit times eop held high
IDLE_BITS, 1, bit times after eop before tx_done

Ports:
clk  in  1  clock
nRST  in  1  reset, asynchronous, active-low
tx_start  in  1  begin packet (sampled in IDLE only)
tx_data  in  8  payload byte
tx_valid  in  1  tx_data valid
tx_last  in  1  qualifies final payload byte (with tx_valid)
tx_ready  out  1  sequencer accepts byte this cycle
piso_load  out  1  one-cycle load strobe to PISO
piso_data  out  8  byte presented with piso_load
piso_shift_enable  out  1  one-cycle bit strobe to PISO
piso_busy  in  1  PISO holding byte
piso_done  in  1  PISO finished 8 shifts (1-cycle pulse)
eop  out  1  drive SE0
tx_active  out  1  high from leaving IDLE to tx_done
tx_done  out  1  one-cycle pulse, packet finished
underrun  out  1  one-cycle pulse, payload starved

Behaviour:
- Reset: every output 0, state IDLE, hold register empty, last_flag 0, counters 0. Reset is asynchronous at any point, including mid-byte and mid-EOP. No residual pulse after release.
- States: IDLE, LOAD, SHIFT, WAIT_DONE, EOP, GAP.
- IDLE: on tx_start, go to LOAD with SYNC_BYTE (8'h80). tx_start is ignored in every other state.
- LOAD: asserts piso_load for one cycle when !piso_busy, with piso_data = byte. Clears tick counter and shift counter, then goes to SHIFT.
- Tick counter: counts 0..CLKS_PER_BIT-1 and wraps.
- SHIFT: piso_shift_enable is high on each wrap, and only while piso_busy. First strobe comes CLKS_PER_BIT cycles after piso_load. Exactly 8 strobes per byte, tracked by a 3-bit shift counter. After the 8th strobe, go to WAIT_DONE.
- WAIT_DONE, on piso_done:
  - Hold register full: next cycle is LOAD with the hold byte.
  - Hold register empty and last_flag set: go to EOP.
  - Hold register empty and last_flag clear: pulse underrun, go to EOP (abort).
- Byte period: load-to-load = 8*CLKS_PER_BIT + 2 cycles.
- Hold register: one byte deep. tx_ready = tx_active && hold empty && !last_flag && state != EOP/GAP.
  - tx_valid && tx_ready writes the hold register.
  - If tx_last is set with that byte, last_flag is set.
  - Loading from hold empties it in the same cycle. A simultaneous accept is not possible because tx_ready is low while the hold register is full.
- EOP: eop = 1 for EOP_BITS*CLKS_PER_BIT cycles. Then GAP for IDLE_BITS*CLKS_PER_BIT cycles with eop = 0. Then tx_done pulses, tx_active drops in the same cycle, and state goes to IDLE.
- last_flag is cleared in IDLE.
- Zero-payload packet (no byte arrives during SYNC) follows the underrun rule.
- CLKS_PER_BIT = 1: a strobe is issued every cycle of SHIFT, starting the cycle after piso_load.

Decomposition:
- Package usb_tx_pkg:
  - state enum tx_seq_state_t
  - SYNC_BYTE = 8'h80
  - default EOP_BITS/IDLE_BITS constants
- Sub-module bit_tick_gen (param CLKS_PER_BIT; inputs clk, nRST, clear, enable; output tick). Reused by the receive side.

Test Plan:
1. CLKS_PER_BIT=4; tx_start plus one byte 0xA5 with tx_last:
   - piso_load with 0x80, then 0xA5 exactly 34 cycles later.
   - 16 shift strobes, spaced 4 cycles apart within each byte.
   - eop high for 8 cycles, then 4 idle cycles.
   - tx_done pulse; underrun never asserted.
2. Three bytes 0x11, 0x22, 0x33 with tx_valid held high and tx_last on 0x33:
   - tx_ready handshakes occur once per byte period.
   - Loads occur in order, 34 cycles apart.
   - No underrun.
3. Send 0x5A without tx_last, then drop tx_valid:
   - After 0x5A's piso_done, an underrun pulse follows.
   - eop for 8 cycles, then tx_done.
4. Pulse tx_start during SHIFT of the SYNC byte:
   - Ignored; a single packet completes with one tx_done.
5. Assert nRST low midway through the second byte:
   - All outputs 0 immediately.
   - After release, a new tx_start transmits a clean packet starting with 0x80.
6. CLKS_PER_BIT=1, one byte 0xFF with tx_last:
   - Strobes on 8 consecutive cycles per byte.
   - Byte period 10 cycles.
   - eop for 2 cycles.
